// File: rtl/banco_pkg.sv
// Shared types and defaults for the register bank and its clear sweep.
// Default build: BANCO_R0_CERO_EN undefined (register 0 is ordinary).
package banco_pkg;

  localparam int ANCHO_DEF       = 16;
  localparam int PROFUNDIDAD_DEF = 8;

  typedef enum logic {
    INACTIVO  = 1'b0,
    BARRIENDO = 1'b1
  } estado_barrido_t;

  // Address width, never narrower than one bit.
  function automatic int dir_ancho(input int p);
    return (p > 2) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/barrido_limpieza.sv
// Sequential clear sweep: walks a pointer over every register once.
// Limpiar is ignored while the sweep is running.
module barrido_limpieza
  import banco_pkg::*;
#(
  parameter int PROFUNDIDAD = PROFUNDIDAD_DEF,
  parameter int DIR_ANCHO   = dir_ancho(PROFUNDIDAD_DEF)
) (
  input  logic                 i_reloj,
  input  logic                 i_reiniciar,
  input  logic                 i_limpiar,
  output logic                 o_ocupado,
  output logic [DIR_ANCHO-1:0] o_puntero,
  output logic                 o_borrar
);

  localparam logic [DIR_ANCHO-1:0] ULTIMO =
    DIR_ANCHO'(PROFUNDIDAD - 1);

  estado_barrido_t      r_estado;
  estado_barrido_t      w_estado_sig;
  logic [DIR_ANCHO-1:0] r_puntero;
  logic [DIR_ANCHO-1:0] w_puntero_sig;

  // State and pointer registers; reset aborts any sweep.
  always_ff @(posedge i_reloj) begin
    if (i_reiniciar) begin
      r_estado  <= INACTIVO;
      r_puntero <= '0;
    end else begin
      r_estado  <= w_estado_sig;
      r_puntero <= w_puntero_sig;
    end
  end

  // Next state, pointer advance and clear strobe.
  always_comb begin
    w_estado_sig  = r_estado;
    w_puntero_sig = r_puntero;
    o_borrar      = 1'b0;
    unique case (r_estado)
      INACTIVO: begin
        if (i_limpiar) begin
          w_estado_sig  = BARRIENDO;
          w_puntero_sig = '0;
        end
      end
      BARRIENDO: begin
        o_borrar = 1'b1;
        if (r_puntero == ULTIMO) begin
          w_estado_sig  = INACTIVO;
          w_puntero_sig = '0;
        end else begin
          w_puntero_sig = r_puntero + 1'b1;
        end
      end
    endcase
  end

  assign o_ocupado = (r_estado == BARRIENDO);
  assign o_puntero = r_puntero;

endmodule

// File: rtl/banco_registros_param.sv
// Register bank: one write port, two registered read ports, clear sweep.
// Macro BANCO_R0_CERO_EN: register 0 hardwired to zero when defined.
module banco_registros_param
  import banco_pkg::*;
#(
  parameter  int ANCHO       = ANCHO_DEF,
  parameter  int PROFUNDIDAD = PROFUNDIDAD_DEF,
  localparam int DIR_ANCHO   = dir_ancho(PROFUNDIDAD)
) (
  input  logic                 Reloj,
  input  logic                 Reiniciar,
  input  logic                 HabilitarEscritura,
  input  logic [DIR_ANCHO-1:0] DireccionEscritura,
  input  logic [ANCHO-1:0]     Entrada,
  input  logic [DIR_ANCHO-1:0] DireccionA,
  input  logic [DIR_ANCHO-1:0] DireccionB,
  input  logic                 Limpiar,
  output logic [ANCHO-1:0]     SalidaA,
  output logic [ANCHO-1:0]     SalidaB,
  output logic                 Ocupado,
  output logic                 EscrituraRechazada
);

  localparam logic [DIR_ANCHO:0] LIMITE =
    (DIR_ANCHO + 1)'(PROFUNDIDAD);

  logic [ANCHO-1:0]     r_mem [PROFUNDIDAD];
  logic [ANCHO-1:0]     r_sal_a;
  logic [ANCHO-1:0]     r_sal_b;
  logic                 r_rechazo;
  logic                 w_ocupado;
  logic                 w_borrar;
  logic [DIR_ANCHO-1:0] w_puntero;
  logic                 w_dir_ok;
  logic                 w_r0;
  logic                 w_acepta;
  logic                 w_rechaza;
  logic [ANCHO-1:0]     w_lect_a;
  logic [ANCHO-1:0]     w_lect_b;

  barrido_limpieza #(
    .PROFUNDIDAD (PROFUNDIDAD),
    .DIR_ANCHO   (DIR_ANCHO)
  ) u_barrido (
    .i_reloj     (Reloj),
    .i_reiniciar (Reiniciar),
    .i_limpiar   (Limpiar),
    .o_ocupado   (w_ocupado),
    .o_puntero   (w_puntero),
    .o_borrar    (w_borrar)
  );

  assign w_dir_ok = {1'b0, DireccionEscritura} < LIMITE;

`ifdef BANCO_R0_CERO_EN
  assign w_r0 = (DireccionEscritura == '0);
`else
  assign w_r0 = 1'b0;
`endif

  // Writes are never accepted during a sweep, so write and clear
  // never target the bank in the same cycle.
  assign w_acepta  = HabilitarEscritura && !w_ocupado
                     && w_dir_ok && !w_r0;
  assign w_rechaza = HabilitarEscritura
                     && (w_ocupado || !w_dir_ok);

  // Read value for one port: stored data, bypassed by a same-cycle
  // write or clear, zero outside the bank.
  function automatic logic [ANCHO-1:0] leer(
    input logic [DIR_ANCHO-1:0] d,
    input logic [ANCHO-1:0]     guardado
  );
    logic [ANCHO-1:0] v;
    v = guardado;
    if (w_acepta && d == DireccionEscritura) v = Entrada;
    if (w_borrar && d == w_puntero) v = '0;
    if ({1'b0, d} >= LIMITE) v = '0;
`ifdef BANCO_R0_CERO_EN
    if (d == '0) v = '0;
`endif
    return v;
  endfunction

  // Combinational read selection for both ports.
  always_comb begin
    w_lect_a = leer(DireccionA, r_mem[DireccionA]);
    w_lect_b = leer(DireccionB, r_mem[DireccionB]);
  end

  // Storage: reset, accepted writes, sweep clears.
  always_ff @(posedge Reloj) begin
    if (Reiniciar) begin
      for (int i = 0; i < PROFUNDIDAD; i++) r_mem[i] <= '0;
    end else begin
      if (w_acepta) r_mem[DireccionEscritura] <= Entrada;
      if (w_borrar) r_mem[w_puntero] <= '0;
    end
  end

  // Registered read ports and rejected-write pulse.
  always_ff @(posedge Reloj) begin
    if (Reiniciar) begin
      r_sal_a   <= '0;
      r_sal_b   <= '0;
      r_rechazo <= 1'b0;
    end else begin
      r_sal_a   <= w_lect_a;
      r_sal_b   <= w_lect_b;
      r_rechazo <= w_rechaza;
    end
  end

  assign SalidaA            = r_sal_a;
  assign SalidaB            = r_sal_b;
  assign Ocupado            = w_ocupado;
  assign EscrituraRechazada = r_rechazo;

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench for banco_registros_param (depth 8 and depth 6).
// Expectations follow BANCO_R0_CERO_EN when it is defined.
module tb_banco_registros_param;

`ifdef BANCO_R0_CERO_EN
  localparam logic [15:0] R0V = 16'h0000;
`else
  localparam logic [15:0] R0V = 16'hAAAA;
`endif

  logic        Reloj = 1'b0;
  logic        rst;
  logic        we, lim;
  logic [2:0]  wa, ra, rb;
  logic [15:0] din;
  logic [15:0] sa, sb;
  logic        ocup, rech;

  logic        we2, lim2;
  logic [2:0]  wa2, ra2, rb2;
  logic [15:0] din2;
  logic [15:0] sa2, sb2;
  logic        ocup2, rech2;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 Reloj = ~Reloj;

  banco_registros_param #(.ANCHO(16), .PROFUNDIDAD(8)) dut (
    .Reloj              (Reloj),
    .Reiniciar          (rst),
    .HabilitarEscritura (we),
    .DireccionEscritura (wa),
    .Entrada            (din),
    .DireccionA         (ra),
    .DireccionB         (rb),
    .Limpiar            (lim),
    .SalidaA            (sa),
    .SalidaB            (sb),
    .Ocupado            (ocup),
    .EscrituraRechazada (rech)
  );

  banco_registros_param #(.ANCHO(16), .PROFUNDIDAD(6)) dut6 (
    .Reloj              (Reloj),
    .Reiniciar          (rst),
    .HabilitarEscritura (we2),
    .DireccionEscritura (wa2),
    .Entrada            (din2),
    .DireccionA         (ra2),
    .DireccionB         (rb2),
    .Limpiar            (lim2),
    .SalidaA            (sa2),
    .SalidaB            (sb2),
    .Ocupado            (ocup2),
    .EscrituraRechazada (rech2)
  );

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] din;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        er;
  } vec_t;

  vec_t v [8];

  task automatic step();
    @(posedge Reloj);
    @(negedge Reloj);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    v[0] = '{1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd1, 16'h0000, 16'h0000, 1'b0};
    v[1] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF, 1'b0};
    v[2] = '{1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 16'h1234, 16'h1234, 1'b0};
    v[3] = '{1'b1, 3'd5, 16'h5555, 3'd5, 3'd3, 16'h5555, 16'hBEEF, 1'b0};
    v[4] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd7, 16'h5555, 16'h0000, 1'b0};
    v[5] = '{1'b1, 3'd0, 16'hAAAA, 3'd0, 3'd3, R0V,      16'hBEEF, 1'b0};
    v[6] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd5, R0V,      16'h5555, 1'b0};
    v[7] = '{1'b1, 3'd7, 16'h7777, 3'd7, 3'd6, 16'h7777, 16'h0000, 1'b0};

    rst = 1'b1; we = 1'b0; lim = 1'b0;
    wa = '0; ra = '0; rb = '0; din = '0;
    we2 = 1'b0; lim2 = 1'b0;
    wa2 = '0; ra2 = '0; rb2 = '0; din2 = '0;
    step();
    step();
    chk("rst_sa", sa, 16'h0);
    chk("rst_sb", sb, 16'h0);
    chk("rst_ocup", ocup, 1'b0);
    chk("rst_rech", rech, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      we = v[i].we; wa = v[i].wa; din = v[i].din;
      ra = v[i].ra; rb = v[i].rb;
      step();
      chk($sformatf("vec%0d_sa", i), sa, v[i].ea);
      chk($sformatf("vec%0d_sb", i), sb, v[i].eb);
      chk($sformatf("vec%0d_rech", i), rech, v[i].er);
    end

    // Fill all registers, then sweep.
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; wa = 3'(i); din = 16'hFFFF;
      step();
    end
    we = 1'b0;
    chk("pre_sweep_ocup", ocup, 1'b0);
    lim = 1'b1;
    step();
    lim = 1'b0;
    n = 0;
    while (ocup && n < 20) begin
      n++;
      we  = (n == 2); wa = 3'd2; din = 16'h1111;
      lim = (n == 4);
      ra  = 3'(n - 1); rb = 3'd7;
      step();
      chk($sformatf("sweep%0d_sa", n), sa, 16'h0);
      chk($sformatf("sweep%0d_sb", n), sb,
          (n == 8) ? 16'h0 : 16'hFFFF);
      chk($sformatf("sweep%0d_rech", n), rech, (n == 2));
    end
    we = 1'b0; lim = 1'b0;
    chk("sweep_len", n, 8);
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(7 - i);
      step();
      chk($sformatf("clr%0d_sa", i), sa, 16'h0);
      chk($sformatf("clr%0d_sb", i), sb, 16'h0);
    end

    // Write and Limpiar together: write lands, sweep clears it.
    we = 1'b1; wa = 3'd1; din = 16'h4242; lim = 1'b1;
    step();
    chk("wf_rech", rech, 1'b0);
    we = 1'b0; lim = 1'b0; ra = 3'd1;
    step();
    chk("wf_sa", sa, 16'h4242);
    n = 0;
    while (ocup && n < 20) begin
      n++;
      step();
    end
    chk("wf_done", ocup, 1'b0);
    step();
    chk("wf_cleared", sa, 16'h0);

    // Reset in the middle of a sweep.
    we = 1'b1; wa = 3'd7; din = 16'h9999;
    step();
    we = 1'b0; lim = 1'b1; ra = 3'd7; rb = 3'd7;
    step();
    lim = 1'b0;
    step();
    step();
    chk("ab_pre_sa", sa, 16'h9999);
    chk("ab_pre_ocup", ocup, 1'b1);
    rst = 1'b1;
    step();
    chk("ab_ocup", ocup, 1'b0);
    chk("ab_sa", sa, 16'h0);
    chk("ab_sb", sb, 16'h0);
    chk("ab_rech", rech, 1'b0);
    rst = 1'b0;
    we = 1'b1; wa = 3'd6; din = 16'h3C3C;
    step();
    chk("ab_wr_rech", rech, 1'b0);
    chk("ab_wr_ocup", ocup, 1'b0);
    chk("ab_r7_zero", sa, 16'h0);
    we = 1'b0; ra = 3'd6;
    step();
    chk("ab_rd6", sa, 16'h3C3C);
    chk("ab_no_resume", ocup, 1'b0);

    // Depth-6 instance: out-of-range addresses.
    we2 = 1'b1; wa2 = 3'd7; din2 = 16'h1111; ra2 = 3'd7;
    step();
    chk("d6_w7_rech", rech2, 1'b1);
    chk("d6_r7", sa2, 16'h0);
    we2 = 1'b1; wa2 = 3'd5; din2 = 16'h5A5A;
    ra2 = 3'd5; rb2 = 3'd6;
    step();
    chk("d6_w5_rech", rech2, 1'b0);
    chk("d6_fwd5", sa2, 16'h5A5A);
    chk("d6_r6", sb2, 16'h0);
    we2 = 1'b0;
    step();
    chk("d6_rd5", sa2, 16'h5A5A);
    chk("d6_rech_pulse", rech2, 1'b0);
    lim2 = 1'b1;
    step();
    lim2 = 1'b0;
    n = 0;
    while (ocup2 && n < 20) begin
      n++;
      step();
    end
    chk("d6_sweep_len", n, 6);
    chk("d6_cleared", sa2, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
